// File: rtl/aes_inv_shift_rows_ser.sv
// Byte-serial AES InvShiftRows: 16-byte fill -> 128-bit block, 1 cycle after the 16th byte; fill stalls at 16 while oBlock is held.
// Define ISR_FWD_MODE_EN to add iEncMode, which selects forward ShiftRows at handoff for the encrypt path.
module aes_inv_shift_rows_ser #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iClear,
  input  logic [7:0]   iByte,
  input  logic         iByteValid,
  output logic         oByteReady,
  output logic [127:0] oBlock,
  output logic         oBlockValid,
`ifdef ISR_FWD_MODE_EN
  input  logic         iEncMode,
`endif
  input  logic         iBlockReady
);

  logic [4:0]   count;
  logic [127:0] fillBuf;
  logic [6:0]   wrBase;
  logic         byteXfer;
  logic         handoff;
  logic         fwdSel;

`ifdef ISR_FWD_MODE_EN
  assign fwdSel = iEncMode;
`else
  assign fwdSel = 1'b0;
`endif

  // State byte m lives at bits [127-8m -: 8]; the first byte lands at m=0 or m=15.
  function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic fwd);
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int src;
        src = fwd ? ((c + r) % 4) : ((c - r + 4) % 4);
        res[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * src) -: 8];
      end
    end
    return res;
  endfunction

  assign oByteReady = (count != 5'd16);
  assign byteXfer   = iByteValid && oByteReady;
  assign handoff    = (count == 5'd16) && (!oBlockValid || iBlockReady) && !iClear;
  assign wrBase     = LSB_FIRST ? {count[3:0], 3'b000} : {~count[3:0], 3'b000};

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      count       <= 5'd0;
      fillBuf     <= '0;
      oBlock      <= '0;
      oBlockValid <= 1'b0;
    end else begin
      // Clear wins over both a byte write and a pending handoff.
      if (iClear || handoff) begin
        count <= 5'd0;
      end else if (byteXfer) begin
        fillBuf[wrBase +: 8] <= iByte;
        count                <= count + 5'd1;
      end

      if (handoff) begin
        oBlock      <= shiftRows(fillBuf, fwdSel);
        oBlockValid <= 1'b1;
      end else if (oBlockValid && iBlockReady) begin
        oBlockValid <= 1'b0;
      end
    end
  end

endmodule
